// File: rtl/count_enable_gen.sv
// Programmable enable-pulse generator feeding the downstream 4-bit counter.
// It divides clk by a latched divisor and emits single-cycle enable pulses,
// either free-running or as a burst of burst_len pulses. It also offers a
// manual single-step pulse and reports busy/done status.
//
// Optional feature macro: BURST_RELOAD_EN
//   When it is defined, a completed burst pulses done and immediately starts
//   another burst of the same length with no gap in pulse spacing. Only stop
//   or reset leave BURST. When it is undefined, a burst runs once and
//   returns to IDLE.
module count_enable_gen #(
    parameter int unsigned DIV_W   = 16,
    parameter int unsigned BURST_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               stop,
    input  logic               mode,
    input  logic [DIV_W-1:0]   div,
    input  logic [BURST_W-1:0] burst_len,
    input  logic               step,
    output logic               enable,
    output logic               busy,
    output logic               done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        BURST = 2'd2
    } state_t;

    state_t               state_q;
    state_t               state_d;
    logic [DIV_W-1:0]     presc_q;
    logic [DIV_W-1:0]     presc_d;
    logic [BURST_W-1:0]   bcnt_q;
    logic [BURST_W-1:0]   bcnt_d;
    logic [DIV_W-1:0]     div_q;
    logic [DIV_W-1:0]     div_d;
    logic [BURST_W-1:0]   len_q;
    logic [BURST_W-1:0]   len_d;
    logic                 mode_q;
    logic                 mode_d;
    logic                 enable_d;
    logic                 busy_d;
    logic                 done_d;

    logic                 pulse_c;
    logic [DIV_W-1:0]     presc_adv_c;
    logic                 burst_last_c;

    // Prescaler terminal count and its wrap-around successor value.
    assign pulse_c     = (presc_q == div_q);
    assign presc_adv_c = pulse_c ? '0 : (presc_q + DIV_W'(1));

    // The final pulse of a burst is on enable right now; the latched mode
    // qualifies burst accounting so free-run never reports completion.
    assign burst_last_c = mode_q && enable && (bcnt_q == len_q);

    // State, prescaler, burst counter, latched configuration and outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            presc_q <= '0;
            bcnt_q  <= '0;
            div_q   <= '0;
            len_q   <= '0;
            mode_q  <= 1'b0;
            enable  <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            bcnt_q  <= bcnt_d;
            div_q   <= div_d;
            len_q   <= len_d;
            mode_q  <= mode_d;
            enable  <= enable_d;
            busy    <= busy_d;
            done    <= done_d;
        end
    end

    // Next-state, counter and registered-output decode.
    always_comb begin
        state_d  = state_q;
        presc_d  = presc_q;
        bcnt_d   = bcnt_q;
        div_d    = div_q;
        len_d    = len_q;
        mode_d   = mode_q;
        enable_d = 1'b0;
        done_d   = 1'b0;
        busy_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (stop) begin
                    // Abort request wins over start and step.
                    state_d = IDLE;
                end else if (start) begin
                    div_d   = div;
                    len_d   = burst_len;
                    mode_d  = mode;
                    presc_d = '0;
                    bcnt_d  = '0;
                    if (!mode) begin
                        state_d = RUN;
                    end else if (burst_len == '0) begin
                        // Empty burst completes at once without pulsing.
                        done_d = 1'b1;
                    end else begin
                        state_d = BURST;
                    end
                end else if (step) begin
                    enable_d = 1'b1;
                end
            end

            RUN: begin
                if (stop) begin
                    state_d = IDLE;
                    presc_d = '0;
                end else begin
                    presc_d  = presc_adv_c;
                    enable_d = pulse_c;
                end
            end

            BURST: begin
                if (stop) begin
                    state_d = IDLE;
                    presc_d = '0;
                    bcnt_d  = '0;
                end
`ifdef BURST_RELOAD_EN
                else begin
                    // Completion restarts the count; the prescaler keeps
                    // running so spacing across bursts stays div+1.
                    done_d   = burst_last_c;
                    presc_d  = presc_adv_c;
                    enable_d = pulse_c;
                    bcnt_d   = (burst_last_c ? '0 : bcnt_q)
                             + (pulse_c ? BURST_W'(1) : BURST_W'(0));
                end
`else
                else if (burst_last_c) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    presc_d = '0;
                    bcnt_d  = '0;
                end else begin
                    presc_d  = presc_adv_c;
                    enable_d = pulse_c;
                    if (pulse_c) begin
                        bcnt_d = bcnt_q + BURST_W'(1);
                    end
                end
`endif
            end

            default: begin
                state_d = IDLE;
                presc_d = '0;
                bcnt_d  = '0;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

endmodule

// File: tb/tb_count_enable_gen.sv
// Scoreboard bench for count_enable_gen: each scenario pushes the expected
// per-cycle enable/busy/done values and pops them as the DUT produces them.
module tb_count_enable_gen;

    localparam int unsigned DIV_W   = 16;
    localparam int unsigned BURST_W = 4;

    logic               clk = 1'b0;
    logic               reset;
    logic               start;
    logic               stop;
    logic               mode;
    logic [DIV_W-1:0]   div;
    logic [BURST_W-1:0] burst_len;
    logic               step;
    logic               enable;
    logic               busy;
    logic               done;

    typedef struct packed {
        logic en;
        logic busy;
        logic done;
    } exp_t;

    exp_t sb[$];
    int   chk_cnt  = 0;
    int   pass_cnt = 0;

    always #5 clk = ~clk;

    count_enable_gen #(.DIV_W(DIV_W), .BURST_W(BURST_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .stop      (stop),
        .mode      (mode),
        .div       (div),
        .burst_len (burst_len),
        .step      (step),
        .enable    (enable),
        .busy      (busy),
        .done      (done)
    );

    function automatic exp_t mk(input bit en, input bit b, input bit d);
        exp_t e;
        e.en = en; e.busy = b; e.done = d;
        return e;
    endfunction

    task automatic idle_inputs();
        start = 0; stop = 0; mode = 0; div = '0; burst_len = '0; step = 0;
    endtask

    task automatic test_reset();
        exp_t e;
        reset = 0; start = 1; mode = 1; div = 16'd5; burst_len = 4'd3; step = 0; stop = 0;
        for (int k = 0; k < 3; k++) sb.push_back(mk(0, 0, 0));
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            e = sb.pop_front(); chk_cnt++;
            if ({enable, busy, done} !== {e.en, e.busy, e.done})
                $display("FAIL reset_hold k=%0d en/busy/done got %b%b%b want %b%b%b", k, enable, busy, done, e.en, e.busy, e.done);
            else pass_cnt++;
        end
        reset = 1; idle_inputs();
        for (int k = 0; k < 3; k++) sb.push_back(mk(0, 0, 0));
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            e = sb.pop_front(); chk_cnt++;
            if ({enable, busy, done} !== {e.en, e.busy, e.done})
                $display("FAIL reset_release k=%0d en/busy/done got %b%b%b want %b%b%b", k, enable, busy, done, e.en, e.busy, e.done);
            else pass_cnt++;
        end
    endtask

    task automatic test_freerun();
        exp_t e;
        int   npulse = 0;
        mode = 0; div = 16'd3; start = 1;
        for (int k = 0; k <= 16; k++)
            sb.push_back(mk((k > 0 && k <= 12 && k % 4 == 0), (k <= 12), 0));
        for (int k = 0; k <= 16; k++) begin
            @(negedge clk);
            e = sb.pop_front(); chk_cnt++;
            if ({enable, busy, done} !== {e.en, e.busy, e.done})
                $display("FAIL freerun k=%0d en/busy/done got %b%b%b want %b%b%b", k, enable, busy, done, e.en, e.busy, e.done);
            else pass_cnt++;
            if (enable === 1'b1) npulse++;
            if (k == 0) start = 0;
            if (k == 12) stop = 1;
            if (k == 13) stop = 0;
        end
        chk_cnt++;
        if (npulse !== 3) $display("FAIL freerun_count got %0d want 3", npulse);
        else pass_cnt++;
        idle_inputs();
    endtask

    task automatic test_burst();
        exp_t       e;
        logic [3:0] cnt4 = 4'd0;
        mode = 1; div = 16'd1; burst_len = 4'd5; start = 1;
        for (int k = 0; k <= 14; k++)
            sb.push_back(mk((k > 0 && k <= 10 && k % 2 == 0), (k <= 10), (k == 11)));
        for (int k = 0; k <= 14; k++) begin
            @(negedge clk);
            e = sb.pop_front(); chk_cnt++;
            if ({enable, busy, done} !== {e.en, e.busy, e.done})
                $display("FAIL burst5 k=%0d en/busy/done got %b%b%b want %b%b%b", k, enable, busy, done, e.en, e.busy, e.done);
            else pass_cnt++;
            if (enable === 1'b1) cnt4 = cnt4 + 4'd1;
            if (k == 0) start = 0;
        end
        chk_cnt++;
        if (cnt4 !== 4'd5) $display("FAIL burst5_counter got %0d want 5", cnt4);
        else pass_cnt++;
        idle_inputs();
    endtask

    task automatic test_burst_zero();
        exp_t e;
        mode = 1; div = 16'd2; burst_len = 4'd0; start = 1;
        for (int k = 0; k <= 4; k++) sb.push_back(mk(0, 0, (k == 0)));
        for (int k = 0; k <= 4; k++) begin
            @(negedge clk);
            e = sb.pop_front(); chk_cnt++;
            if ({enable, busy, done} !== {e.en, e.busy, e.done})
                $display("FAIL burst0 k=%0d en/busy/done got %b%b%b want %b%b%b", k, enable, busy, done, e.en, e.busy, e.done);
            else pass_cnt++;
            if (k == 0) start = 0;
        end
        idle_inputs();
    endtask

    task automatic test_stop_mid_burst();
        exp_t e;
        int   npulse = 0;
        mode = 1; div = 16'd0; burst_len = 4'd15; start = 1;
        for (int k = 0; k <= 11; k++)
            sb.push_back(mk((k >= 1 && k <= 7), (k <= 7), 0));
        for (int k = 0; k <= 11; k++) begin
            @(negedge clk);
            e = sb.pop_front(); chk_cnt++;
            if ({enable, busy, done} !== {e.en, e.busy, e.done})
                $display("FAIL stop_burst k=%0d en/busy/done got %b%b%b want %b%b%b", k, enable, busy, done, e.en, e.busy, e.done);
            else pass_cnt++;
            if (enable === 1'b1) npulse++;
            if (k == 0) start = 0;
            if (k == 7) stop = 1;
            if (k == 8) stop = 0;
        end
        chk_cnt++;
        if (npulse !== 7) $display("FAIL stop_burst_count got %0d want 7", npulse);
        else pass_cnt++;
        idle_inputs();
    endtask

    task automatic test_reset_mid_burst();
        exp_t e;
        mode = 1; div = 16'd0; burst_len = 4'd15; start = 1;
        for (int k = 0; k <= 9; k++)
            sb.push_back(mk((k >= 1 && k <= 3), (k <= 3), 0));
        for (int k = 0; k <= 9; k++) begin
            @(negedge clk);
            e = sb.pop_front(); chk_cnt++;
            if ({enable, busy, done} !== {e.en, e.busy, e.done})
                $display("FAIL reset_burst k=%0d en/busy/done got %b%b%b want %b%b%b", k, enable, busy, done, e.en, e.busy, e.done);
            else pass_cnt++;
            if (k == 0) start = 0;
            if (k == 3) reset = 0;
            if (k == 5) reset = 1;
        end
        idle_inputs();
    endtask

    task automatic test_step();
        exp_t e;
        step = 1;
        sb.push_back(mk(1, 0, 0));
        sb.push_back(mk(0, 0, 0));
        for (int k = 0; k <= 1; k++) begin
            @(negedge clk);
            e = sb.pop_front(); chk_cnt++;
            if ({enable, busy, done} !== {e.en, e.busy, e.done})
                $display("FAIL step_single k=%0d en/busy/done got %b%b%b want %b%b%b", k, enable, busy, done, e.en, e.busy, e.done);
            else pass_cnt++;
            if (k == 0) step = 0;
        end
        step = 1;
        for (int k = 0; k <= 4; k++) sb.push_back(mk((k <= 2), 0, 0));
        for (int k = 0; k <= 4; k++) begin
            @(negedge clk);
            e = sb.pop_front(); chk_cnt++;
            if ({enable, busy, done} !== {e.en, e.busy, e.done})
                $display("FAIL step_held k=%0d en/busy/done got %b%b%b want %b%b%b", k, enable, busy, done, e.en, e.busy, e.done);
            else pass_cnt++;
            if (k == 2) step = 0;
        end
        idle_inputs();
    endtask

    task automatic test_busy_ignores();
        exp_t e;
        mode = 0; div = 16'd3; start = 1;
        for (int k = 0; k <= 10; k++)
            sb.push_back(mk((k > 0 && k <= 8 && k % 4 == 0), (k <= 8), 0));
        for (int k = 0; k <= 10; k++) begin
            @(negedge clk);
            e = sb.pop_front(); chk_cnt++;
            if ({enable, busy, done} !== {e.en, e.busy, e.done})
                $display("FAIL run_ignores k=%0d en/busy/done got %b%b%b want %b%b%b", k, enable, busy, done, e.en, e.busy, e.done);
            else pass_cnt++;
            if (k == 0) start = 0;
            if (k == 1) begin step = 1; div = 16'd0; mode = 1; burst_len = 4'd1; end
            if (k == 2) start = 1;
            if (k == 3) begin step = 0; start = 0; end
            if (k == 8) stop = 1;
            if (k == 9) stop = 0;
        end
        idle_inputs();
    endtask

    task automatic test_start_stop();
        exp_t e;
        start = 1; stop = 1; step = 1; mode = 0; div = 16'd0;
        for (int k = 0; k <= 3; k++) sb.push_back(mk(0, 0, 0));
        for (int k = 0; k <= 3; k++) begin
            @(negedge clk);
            e = sb.pop_front(); chk_cnt++;
            if ({enable, busy, done} !== {e.en, e.busy, e.done})
                $display("FAIL start_stop k=%0d en/busy/done got %b%b%b want %b%b%b", k, enable, busy, done, e.en, e.busy, e.done);
            else pass_cnt++;
            if (k == 0) idle_inputs();
        end
    endtask

`ifdef BURST_RELOAD_EN
    task automatic test_reload();
        exp_t e;
        mode = 1; div = 16'd2; burst_len = 4'd3; start = 1;
        for (int k = 0; k <= 33; k++)
            sb.push_back(mk((k > 0 && k <= 30 && k % 3 == 0), (k <= 30),
                            (k >= 10 && k <= 30 && (k - 10) % 9 == 0)));
        for (int k = 0; k <= 33; k++) begin
            @(negedge clk);
            e = sb.pop_front(); chk_cnt++;
            if ({enable, busy, done} !== {e.en, e.busy, e.done})
                $display("FAIL reload k=%0d en/busy/done got %b%b%b want %b%b%b", k, enable, busy, done, e.en, e.busy, e.done);
            else pass_cnt++;
            if (k == 0) start = 0;
            if (k == 30) stop = 1;
            if (k == 31) stop = 0;
        end
        idle_inputs();
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_freerun();
`ifndef BURST_RELOAD_EN
        test_burst();
`endif
        test_burst_zero();
        test_stop_mid_burst();
        test_reset_mid_burst();
        test_step();
        test_busy_ignores();
        test_start_stop();
`ifdef BURST_RELOAD_EN
        test_reload();
`endif
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
